// File: rtl/rst_seq_if.sv
// Button input and staged-reset outputs of the reset sequencer, bundled for rst_seq.
// The sequencer takes the master modport; whatever drives btn and consumes the resets takes slave.
interface rst_seq_if #(
    parameter int STAGES = 3
);
    logic              btn;
    logic [STAGES-1:0] rst_out;
    logic              seq_done;

    modport master (
        input  btn,
        output rst_out,
        output seq_done
    );

    modport slave (
        output btn,
        input  rst_out,
        input  seq_done
    );
endinterface

// File: rtl/rst_seq.sv
// Staged reset sequencer: releases rst_out[0..STAGES-1] one at a time, GAP cycles apart.
// Define RST_SEQ_BTN_EN to compile in the debounced user button that re-runs the sequence.
module rst_seq #(
    parameter int STAGES   = 3,
    parameter int GAP      = 16,
    parameter int DEBOUNCE = 1000
) (
    input  logic     clk,
    input  logic     rst_n,
    rst_seq_if.master bus
);
    localparam int CNT_W = $clog2(GAP + 1);
    localparam int IDX_W = $clog2(STAGES + 1);
    localparam int DEB_W = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_SEQ  = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc_s;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [STAGES-1:0] rst_out_q, rst_out_d;
    logic              seq_done_q, seq_done_d;
    logic              adv_s;
    logic              btn_hold_s;
    logic              trig_s;

`ifdef RST_SEQ_BTN_EN
    logic             sync1_q, sync2_q;
    logic [DEB_W-1:0] deb_q, deb_d;

    // Button synchronizer and debounce counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= '0;
        end else begin
            sync1_q <= bus.btn;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
        end
    end

    // Debounce counter: count synced-high cycles, saturating at DEBOUNCE
    always_comb begin
        deb_d = deb_q;
        if (!sync2_q) begin
            deb_d = '0;
        end else if (deb_q != DEB_W'(DEBOUNCE)) begin
            deb_d = deb_q + DEB_W'(1);
        end else begin
            deb_d = deb_q;
        end
    end

    // Trigger only on the edge the counter arrives at DEBOUNCE, not while it sits there
    assign btn_hold_s = sync2_q;
    assign trig_s     = sync2_q && (deb_q == DEB_W'(DEBOUNCE - 1));
`else
    logic unused_btn_s;
    assign unused_btn_s = bus.btn;
    assign btn_hold_s   = 1'b0;
    assign trig_s       = 1'b0;
`endif

    assign cnt_inc_s = cnt_q + CNT_W'(1);

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_HOLD;
            cnt_q      <= '0;
            idx_q      <= '0;
            rst_out_q  <= '1;
            seq_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            rst_out_q  <= rst_out_d;
            seq_done_q <= seq_done_d;
        end
    end

    // Next-state logic; the HOLD exit edge already counts as the first gap cycle
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        rst_out_d  = rst_out_q;
        seq_done_d = seq_done_q;
        adv_s      = 1'b0;

        case (state_q)
            ST_HOLD: begin
                if (btn_hold_s) begin
                    cnt_d      = '0;
                    idx_d      = '0;
                    rst_out_d  = '1;
                    seq_done_d = 1'b0;
                end else begin
                    adv_s = 1'b1;
                end
            end
            ST_SEQ: begin
                adv_s = 1'b1;
            end
            ST_RUN: begin
                rst_out_d  = '0;
                seq_done_d = 1'b1;
            end
            default: begin
                state_d    = ST_HOLD;
                cnt_d      = '0;
                idx_d      = '0;
                rst_out_d  = '1;
                seq_done_d = 1'b0;
            end
        endcase

        if (adv_s) begin
            if (cnt_inc_s == CNT_W'(GAP)) begin
                cnt_d = '0;
                idx_d = idx_q + IDX_W'(1);
                for (int i = 0; i < STAGES; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        rst_out_d[i] = 1'b0;
                    end else begin
                        rst_out_d[i] = rst_out_q[i];
                    end
                end
                if (idx_q == IDX_W'(STAGES - 1)) begin
                    state_d    = ST_RUN;
                    seq_done_d = 1'b1;
                end else begin
                    state_d = ST_SEQ;
                end
            end else begin
                cnt_d   = cnt_inc_s;
                state_d = ST_SEQ;
            end
        end else begin
            cnt_d = cnt_d;
        end

        // A button trigger beats any release scheduled for the same edge
        if (trig_s) begin
            state_d    = ST_HOLD;
            cnt_d      = '0;
            idx_d      = '0;
            rst_out_d  = '1;
            seq_done_d = 1'b0;
        end else begin
            seq_done_d = seq_done_d;
        end
    end

    assign bus.rst_out  = rst_out_q;
    assign bus.seq_done = seq_done_q;
endmodule
